mul_seq_ctrl: RTL and testbench
===============================

Name: mul_seq_ctrl

Overview:
- Multi-cycle 16x16 multiply sequencer for the single-cycle core's MUL path. It reuses the shared 16-bit carry-lookahead add/sub unit instead of instantiating a multiplier.
- Performs radix-2 Booth (signed) or shift-add (unsigned) over 16 iterations, with a Start/Busy/Done handshake to the control unit.
- Drives the adder's A/B/Cin/isSub inputs and consumes its sum and carry-out. The adder sits outside this block.

Parameters:
- WIDTH, 16, operand width; fixed by the adder width, not overridable in practice.
- CNT_W, 4, iteration counter width, log2(WIDTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Start  in  1  request pulse; sampled only in IDLE or DONE.
- Signed  in  1  1 = two's-complement Booth, 0 = unsigned shift-add; latched at Start.
- Mcand  in  16  multiplicand M; latched at Start.
- Mplier  in  16  multiplier Q; latched at Start.
- AddA  out  16  adder operand A, equal to the accumulator register.
- AddB  out  16  adder operand B: M, or ~M when subtracting, or 0 when idle/no-op.
- AddCin  out  1  1 when subtracting, else 0.
- AddIsSub  out  1  1 when subtracting, else 0.
- AddS  in  16  adder sum.
- AddCout  in  1  adder carry-out.
- Busy  out  1  high in RUN.
- Done  out  1  one-cycle pulse in DONE.
- Product  out  32  {Acc, Q}; valid and held from DONE until the next accepted Start.

Behaviour:
- Reset values (asynchronous): state=IDLE; Acc, Q, M, qm1 (Booth extra bit), Cnt = 0; Busy=0, Done=0, Product=0.
- IDLE: AddB=0, AddCin=0, AddIsSub=0.
- IDLE or DONE with Start=1: load M=Mcand, Q=Mplier, Acc=0, qm1=0, Cnt=0, latch Signed; next state RUN.
- DONE with Start=0: next state IDLE; Product keeps its value.
- RUN, one iteration per clock, op selection:
  - Signed, {Q[0],qm1}=01: add M.
  - Signed, {Q[0],qm1}=10: subtract (AddB=~M, AddCin=1, AddIsSub=1).
  - Signed, 00 or 11: no-op (AddB=0, AddCin=0, AddIsSub=0).
  - Unsigned: Q[0]=1 adds M; Q[0]=0 is a no-op.
- RUN, shift-in bit ext:
  - Signed: ext = AddA[15] ^ AddB[15] ^ AddCout, the true 17-bit sign. This covers the M=0x8000 overflow case.
  - Unsigned: ext = AddCout.
- RUN, register update: {Acc,Q,qm1} <= {ext, AddS, Q} (shift right one, 33 bits total). Cnt <= Cnt+1.
- RUN exit: when Cnt==15 at the clock edge, next state DONE.
- Latency: the edge sampling Start begins RUN; Done=1 in the cycle after 16 RUN cycles, i.e. 17 edges after the start edge.
- Busy: high for exactly 16 cycles per operation.
- Start during RUN: ignored; operands and mode stay unchanged.
- Start in the DONE cycle: accepted (back-to-back). Next cycle is RUN, Done deasserts, and Product is overwritten progressively.
- Product: combinationally {Acc,Q}. It is guaranteed meaningful only in DONE/IDLE after completion.
- Reset mid-RUN: immediate return to IDLE, all registers cleared, no Done pulse.
- Adder is purely combinational to this block. No adder output is registered beyond Acc/Q.

Decomposition:
- Shared package (core_pkg): state enum {IDLE, RUN, DONE} as a 2-bit encoding; MUL_WIDTH=16 constant.
- Optional sub-module mul_op_sel: combinational Booth/shift-add op decoder producing AddB/AddCin/AddIsSub from Q[0], qm1, Signed, M.
- Everything else is one flat module.

Test Plan:
- Signed, Mcand=0x0003, Mplier=0xFFFB (3 x -5) -> Done at start+17; Product=0xFFFFFFF1; Busy high for exactly 16 cycles.
- Signed, 0x8000 x 0x8000 -> Product=0x40000000 (exercises the overflow-corrected ext bit).
- Unsigned, 0xFFFF x 0xFFFF -> Product=0xFFFE0001. Also unsigned 0x1234 x 0x0000 -> Product=0x00000000.
- Start re-pulsed at cycle 5 of RUN with different operands -> ignored; result equals the first operation. Start held high in the DONE cycle with 0x0007 x 0x0006 (signed) -> second op begins immediately; Product=0x0000002A, 17 cycles later.
- rst_n low at RUN cycle 8 -> Busy=0, Done=0, Product=0 immediately. A new Start after release gives the correct result (0x0100 x 0x0100 unsigned -> 0x00010000).
- Random signed/unsigned operand sweep (≥1000 ops) against a reference model -> Product matches bit-exactly every operation.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: multiply sequencer state encoding, operand width
// and the adder-control bundle that the op decoder produces.
package core_pkg;

  localparam int MUL_WIDTH = 16;

  typedef logic [1:0] mul_state_t;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic [MUL_WIDTH-1:0] b;
    logic                 cin;
    logic                 is_sub;
  } add_op_t;

endpackage

// File: rtl/mul_op_sel.sv
// Per-iteration operation decoder: chooses add M, subtract M (as ~M + 1)
// or no-op for radix-2 Booth (signed) or plain shift-add (unsigned).
module mul_op_sel
  import core_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic             active,
  input  logic             signed_mode,
  input  logic             q0,
  input  logic             qm1,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  output logic             add_is_sub
);

  always_comb begin
    add_b      = '0;
    add_cin    = 1'b0;
    add_is_sub = 1'b0;
    if (active) begin
      if (signed_mode) begin
        case ({q0, qm1})
          2'b01: add_b = m;
          2'b10: begin
            add_b      = ~m;
            add_cin    = 1'b1;
            add_is_sub = 1'b1;
          end
          default: add_b = '0;
        endcase
      end else if (q0) begin
        add_b = m;
      end
    end
  end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Multi-cycle 16x16 multiply sequencer driving the shared external add/sub
// unit: 16 Booth or shift-add iterations with a Start/Busy/Done handshake.
module mul_seq_ctrl
  import core_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               Start,
  input  logic               Signed,
  input  logic [WIDTH-1:0]   Mcand,
  input  logic [WIDTH-1:0]   Mplier,
  output logic [WIDTH-1:0]   AddA,
  output logic [WIDTH-1:0]   AddB,
  output logic               AddCin,
  output logic               AddIsSub,
  input  logic [WIDTH-1:0]   AddS,
  input  logic               AddCout,
  output logic               Busy,
  output logic               Done,
  output logic [2*WIDTH-1:0] Product
);

  mul_state_t       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             qm1_q, qm1_d;
  logic             signed_q, signed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run;
  logic             ext;

  assign run = (state_q == ST_RUN);

  mul_op_sel #(.WIDTH(WIDTH)) u_op_sel (
    .active      (run),
    .signed_mode (signed_q),
    .q0          (q_q[0]),
    .qm1         (qm1_q),
    .m           (m_q),
    .add_b       (AddB),
    .add_cin     (AddCin),
    .add_is_sub  (AddIsSub)
  );

  // Bit 16 of the sign-extended sum; the adder's own MSB is wrong on overflow.
  assign ext = signed_q ? (acc_q[WIDTH-1] ^ AddB[WIDTH-1] ^ AddCout) : AddCout;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    q_d      = q_q;
    m_d      = m_q;
    qm1_d    = qm1_q;
    signed_d = signed_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          state_d  = ST_RUN;
          acc_d    = '0;
          q_d      = Mplier;
          m_d      = Mcand;
          qm1_d    = 1'b0;
          signed_d = Signed;
          cnt_d    = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        {acc_d, q_d, qm1_d} = {ext, AddS, q_q};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      q_q      <= '0;
      m_q      <= '0;
      qm1_q    <= 1'b0;
      signed_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      q_q      <= q_d;
      m_q      <= m_d;
      qm1_q    <= qm1_d;
      signed_q <= signed_d;
      cnt_q    <= cnt_d;
    end
  end

  assign AddA    = acc_q;
  assign Busy    = run;
  assign Done    = (state_q == ST_DONE);
  assign Product = {acc_q, q_q};

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed vector table, hand-written handshake corner cases and a random
// sweep for mul_seq_ctrl, with a behavioural model of the external adder.
module tb_mul_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sgn;
  logic [15:0] mcand;
  logic [15:0] mplier;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic        add_cin;
  logic        add_is_sub;
  logic [15:0] add_s;
  logic        add_cout;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int checks = 0;
  int errors = 0;

  mul_seq_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Start    (start),
    .Signed   (sgn),
    .Mcand    (mcand),
    .Mplier   (mplier),
    .AddA     (add_a),
    .AddB     (add_b),
    .AddCin   (add_cin),
    .AddIsSub (add_is_sub),
    .AddS     (add_s),
    .AddCout  (add_cout),
    .Busy     (busy),
    .Done     (done),
    .Product  (product)
  );

  // External carry-lookahead adder: B already arrives inverted for subtracts.
  always_comb begin
    {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Caller is at a negedge; returns at the negedge just after the start edge.
  task automatic launch(input logic s, input logic [15:0] a, input logic [15:0] b);
    sgn    = s;
    mcand  = a;
    mplier = b;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Counts edges from the start edge until Done; optionally re-pulses Start
  // with other operands at RUN cycle rp.
  task automatic wait_done(input int rp, output int edges, output int busy_cnt, output bit seen);
    edges    = 1;
    busy_cnt = 0;
    seen     = 1'b0;
    while (edges < 40) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
      if (rp != 0 && edges == rp) begin
        start  = 1'b1;
        sgn    = ~sgn;
        mcand  = 16'h5A5A;
        mplier = 16'h0F0F;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      edges++;
    end
    start = 1'b0;
  endtask

  task automatic check_op(input string name, input logic [31:0] exp, input int edges,
                          input int busy_cnt, input bit seen, input bit timing);
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
    if (timing) begin
      chk({name, "_latency"}, 32'(edges), 32'd17);
      chk({name, "_busy_cycles"}, 32'(busy_cnt), 32'd16);
    end
    chk({name, "_product"}, product, exp);
    $display("op %s: product=%h expected=%h latency=%0d busy=%0d", name, product, exp, edges, busy_cnt);
  endtask

  task automatic after_done(input string name, input logic [31:0] exp);
    @(negedge clk);
    chk({name, "_done_pulse"}, 32'(done), 32'd0);
    chk({name, "_held"}, product, exp);
  endtask

  initial begin
    int          edges;
    int          busy_cnt;
    bit          seen;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rs;
    longint      pa;
    longint      pb;
    logic [31:0] rexp;

    vecs[0] = '{1'b1, 16'h0003, 16'hFFFB, 32'hFFFFFFF1};
    vecs[1] = '{1'b1, 16'h8000, 16'h8000, 32'h40000000};
    vecs[2] = '{1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001};
    vecs[3] = '{1'b0, 16'h1234, 16'h0000, 32'h00000000};
    vecs[4] = '{1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001};
    vecs[5] = '{1'b1, 16'h7FFF, 16'h8000, 32'hC0008000};
    vecs[6] = '{1'b0, 16'h8000, 16'h8000, 32'h40000000};
    vecs[7] = '{1'b0, 16'hFFFF, 16'h0002, 32'h0001FFFE};
    vecs[8] = '{1'b1, 16'hFFFF, 16'h0002, 32'hFFFFFFFE};
    vecs[9] = '{1'b1, 16'h0007, 16'h0006, 32'h0000002A};

    rst_n  = 1'b0;
    start  = 1'b0;
    sgn    = 1'b0;
    mcand  = 16'h0;
    mplier = 16'h0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_product", product, 32'd0);
    chk("reset_addb", 32'(add_b), 32'd0);
    chk("reset_addcin", 32'(add_cin), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_addb", 32'(add_b), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // First Booth step of 3 x -5 is a subtract: Q[0]=1, qm1=0.
    launch(1'b1, 16'h0003, 16'hFFFB);
    chk("sub_addb", 32'(add_b), 32'h0000FFFC);
    chk("sub_addcin", 32'(add_cin), 32'd1);
    chk("sub_addissub", 32'(add_is_sub), 32'd1);
    chk("sub_adda", 32'(add_a), 32'd0);
    wait_done(0, edges, busy_cnt, seen);
    check_op("first", 32'hFFFFFFF1, edges, busy_cnt, seen, 1'b1);
    after_done("first", 32'hFFFFFFF1);

    for (int i = 0; i < 10; i++) begin
      launch(vecs[i].sgn, vecs[i].a, vecs[i].b);
      wait_done(0, edges, busy_cnt, seen);
      check_op($sformatf("vec%0d", i), vecs[i].exp, edges, busy_cnt, seen, 1'b1);
      after_done($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Start during RUN must not disturb the operation in flight.
    launch(1'b1, 16'h0003, 16'hFFFB);
    wait_done(5, edges, busy_cnt, seen);
    check_op("ignore_restart", 32'hFFFFFFF1, edges, busy_cnt, seen, 1'b1);
    after_done("ignore_restart", 32'hFFFFFFF1);

    // Back-to-back: Start held in the DONE cycle.
    launch(1'b0, 16'h0010, 16'h0010);
    wait_done(0, edges, busy_cnt, seen);
    check_op("b2b_first", 32'h00000100, edges, busy_cnt, seen, 1'b1);
    launch(1'b1, 16'h0007, 16'h0006);
    chk("b2b_done_drop", 32'(done), 32'd0);
    chk("b2b_busy_rise", 32'(busy), 32'd1);
    wait_done(0, edges, busy_cnt, seen);
    check_op("b2b_second", 32'h0000002A, edges, busy_cnt, seen, 1'b1);
    after_done("b2b_second", 32'h0000002A);

    // Asynchronous reset in the middle of RUN.
    launch(1'b0, 16'hFFFF, 16'hFFFF);
    repeat (7) @(negedge clk);
    chk("midrun_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_busy", 32'(busy), 32'd0);
    chk("midrun_rst_done", 32'(done), 32'd0);
    chk("midrun_rst_product", product, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_done", 32'(done), 32'd0);
    launch(1'b0, 16'h0100, 16'h0100);
    wait_done(0, edges, busy_cnt, seen);
    check_op("post_rst", 32'h00010000, edges, busy_cnt, seen, 1'b1);
    after_done("post_rst", 32'h00010000);

    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom_range(0, 1));
      pa = rs ? longint'($signed(ra)) : longint'(ra);
      pb = rs ? longint'($signed(rb)) : longint'(rb);
      rexp = 32'(pa * pb);
      launch(rs, ra, rb);
      wait_done(0, edges, busy_cnt, seen);
      check_op($sformatf("rand%0d_%s_%h_%h", i, rs ? "s" : "u", ra, rb), rexp, edges, busy_cnt, seen, 1'b0);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
